// File: rtl/a_input_stage.sv
// -----------------------------------------------------------------------------
// a_input_stage : A-operand input pipeline of the DSP slice
//
// Selects the operand source (direct a port or acin cascade), then passes it
// through 0, 1 or 2 clock-enabled register stages (A1, A2). The operand goes
// to the pre-adder/multiplier on a_out and to the next slice on acout.
//
// Parameters
//   A_WIDTH  : operand width in bits
//   AREG     : datapath register stages (0, 1, 2)
//   ACASCREG : register stages before acout (0, 1, 2); legal pairs with AREG
//              are (0,0), (1,1), (2,1) and (2,2)
//   A_INPUT  : 0 = a port (direct), 1 = acin port (cascade)
//
// Ports
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset, clears A1 and A2
//   a      in   direct operand
//   acin   in   cascade operand from the previous slice
//   cea1   in   clock enable for A1
//   cea2   in   clock enable for A2
//   a1_sel in   datapath tap when AREG = 2: 1 = A1, 0 = A2
//   a_out  out  operand to the pre-adder/multiplier
//   acout  out  cascade operand to the next slice
// -----------------------------------------------------------------------------

// Clock-enabled register with synchronous reset; reset beats the enable.
module dff #(
   parameter int signal_width = 30
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ce,
   input  logic [signal_width-1:0] d,
   output logic [signal_width-1:0] q
);

   logic [signal_width-1:0] r_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its input from before the edge, regardless of process order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_q <= '0;
      end else if (ce) begin
         r_q <= d;
      end
   end

   assign q = r_q;

endmodule

module a_input_stage #(
   parameter int A_WIDTH  = 30,
   parameter int AREG     = 1,
   parameter int ACASCREG = 1,
   parameter int A_INPUT  = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [A_WIDTH-1:0] a,
   input  logic [A_WIDTH-1:0] acin,
   input  logic               cea1,
   input  logic               cea2,
   input  logic               a1_sel,
   output logic [A_WIDTH-1:0] a_out,
   output logic [A_WIDTH-1:0] acout
);

   localparam bit LEGAL_REGS =
      ((AREG == 0) && (ACASCREG == 0)) ||
      ((AREG == 1) && (ACASCREG == 1)) ||
      ((AREG == 2) && ((ACASCREG == 1) || (ACASCREG == 2)));
   localparam bit LEGAL_SRC = (A_INPUT == 0) || (A_INPUT == 1);

   logic [A_WIDTH-1:0] w_src;

   // Source select is fixed at elaboration; no runtime mux control exists.
   assign w_src = (A_INPUT == 1) ? acin : a;

   // Inputs that a given configuration does not need are folded into one
   // sink so every configuration stays free of dangling-input warnings.
   logic w_unused;
   assign w_unused = ^{clk, rst, a, acin, cea1, cea2, a1_sel};

   if (!LEGAL_REGS || !LEGAL_SRC) begin : g_illegal
      $fatal(1, "a_input_stage: illegal parameters AREG=%0d ACASCREG=%0d A_INPUT=%0d",
             AREG, ACASCREG, A_INPUT);
   end else if (AREG == 2) begin : g_areg2
      logic [A_WIDTH-1:0] w_a1;
      logic [A_WIDTH-1:0] w_a2;

      dff #(.signal_width(A_WIDTH)) u_a1 (
         .clk (clk),
         .rst (rst),
         .ce  (cea1),
         .d   (w_src),
         .q   (w_a1)
      );

      // A2 re-samples A1, so cea2 alone can move a held A1 value forward.
      dff #(.signal_width(A_WIDTH)) u_a2 (
         .clk (clk),
         .rst (rst),
         .ce  (cea2),
         .d   (w_a1),
         .q   (w_a2)
      );

      // a1_sel is a live mux select, giving 1- or 2-cycle latency on the fly.
      assign a_out = a1_sel ? w_a1 : w_a2;
      assign acout = (ACASCREG == 1) ? w_a1 : w_a2;
   end else if (AREG == 1) begin : g_areg1
      logic [A_WIDTH-1:0] w_a2;

      dff #(.signal_width(A_WIDTH)) u_a2 (
         .clk (clk),
         .rst (rst),
         .ce  (cea2),
         .d   (w_src),
         .q   (w_a2)
      );

      assign a_out = w_a2;
      assign acout = w_a2;
   end else begin : g_areg0
      // Fully combinational pass-through; rst and enables have no effect.
      assign a_out = w_src;
      assign acout = w_src;
   end

endmodule

// File: doc/a_input_stage.md
Name: a_input_stage

Overview:
- A-operand input pipeline of the DSP slice. Sits directly upstream of the multiplier/pre-adder.
- Selects the data source (direct A port or ACIN cascade) and passes it through 0, 1 or 2 clock-enabled register stages (A1, A2).
- Drives two outputs: the registered operand to the datapath, and the ACOUT cascade to the next slice.
- Each register stage is a dff instance (signal_width = A_WIDTH).

Parameters:
- A_WIDTH, 30, operand width in bits.
- AREG, 1, number of pipeline stages on the datapath output: 0, 1 or 2.
- ACASCREG, 1, number of stages before acout: 0, 1 or 2. Must be ≤ AREG. ACASCREG = 0 is legal only when AREG = 0. ACASCREG = 1 or 2 is legal when AREG = 2.
- A_INPUT, 0, data source: 0 = a port (DIRECT), 1 = acin port (CASCADE).

Ports:
- clk, input, 1, clock; all registers update on the rising edge.
- rst, input, 1, synchronous active-high reset; clears A1 and A2.
- a, input, A_WIDTH, direct operand.
- acin, input, A_WIDTH, cascade operand from the previous slice.
- cea1, input, 1, clock enable for A1.
- cea2, input, 1, clock enable for A2.
- a1_sel, input, 1, datapath tap when AREG = 2: 1 = A1, 0 = A2. Ignored otherwise.
- a_out, output, A_WIDTH, operand to the pre-adder/multiplier.
- acout, output, A_WIDTH, cascade output to the next slice.

Behaviour:
- Source mux (combinational): src = A_INPUT ? acin : a.
- A1 register:
  - Exists only when AREG = 2.
  - rst=1 → A1 <= 0; else if cea1 → A1 <= src; else hold.
- A2 register:
  - Exists when AREG ≥ 1.
  - Input is A1 when AREG = 2, src when AREG = 1.
  - rst=1 → A2 <= 0; else if cea2 → A2 <= its input; else hold.
- Reset has priority over both enables. There is no asynchronous path.
- a_out:
  - AREG = 0: src, combinational, zero latency.
  - AREG = 1: A2, 1-cycle latency.
  - AREG = 2: a1_sel ? A1 : A2; 1 or 2 cycles latency. a1_sel is combinational, applied in the same cycle.
- acout:
  - ACASCREG = 0: src.
  - ACASCREG = 1: A1 if AREG = 2, A2 if AREG = 1.
  - ACASCREG = 2: A2.
- Reset values:
  - AREG ≥ 1: a_out = 0 the cycle after rst is sampled high.
  - ACASCREG ≥ 1: acout = 0 the cycle after rst is sampled high.
  - AREG = 0: outputs follow inputs, unaffected by rst.
- Illegal parameter combinations:
  - Cases: ACASCREG > AREG; AREG = 2 with ACASCREG = 0; AREG = 1 with ACASCREG ≠ 1; AREG = 0 with ACASCREG ≠ 0; any value > 2.
  - Response: elaboration-time error via generate-if plus a $fatal/$error message. No silent fallback.
- Enable independence:
  - cea1=1, cea2=0 → A1 advances, A2 holds.
  - cea1=0, cea2=1 → A2 re-samples the held A1.
- Reset mid-operation: any in-flight data is discarded. Both stages read 0 until re-enabled and new data propagates: 1 cycle for A1, 2 for A2 at AREG = 2.
- rst=1 with cea=1 in the same cycle → register = 0 (reset wins).
- Widths: no sign handling, pure pass-through. All paths are A_WIDTH; no truncation or extension.

Test Plan:
1. AREG=2, ACASCREG=2, A_INPUT=0, a1_sel=0, cea1=cea2=1. Apply rst for 1 cycle, then a = 5, 9, 13 on consecutive negedges → a_out = acout = 0 after reset, then 5, 9, 13 exactly 2 cycles after each input.
2. Same config with a1_sel=1 and ACASCREG=1. Apply a=0x3FFFFFFF → a_out and acout = 0x3FFFFFFF 1 cycle later; A2 still holds its previous value.
3. AREG=2: load A1=A2=7, then a=21 with cea1=1, cea2=0 for 3 cycles → A2 (a_out with a1_sel=0) stays 7. Raise cea2=1 for 1 cycle → a_out = 21.
4. AREG=1, ACASCREG=1, A_INPUT=1: acin=100, a=55, cea2=1 → a_out = acout = 100 next cycle. Assert rst with cea2=1 → both 0 next cycle.
5. AREG=0, ACASCREG=0: a = 42 → a_out = acout = 42 in the same cycle. Toggling rst has no effect.
6. Randomised run: 500 cycles of random a, acin, cea1, cea2 for each legal parameter set. A scoreboard model is compared every negedge, with display of rst, enables, inputs and outputs.
